// File: rtl/buscaminas_pkg.sv
// Shared definitions for the minesweeper game sequencer.
// Holds the board geometry, the sequencer state encoding, the per-cell
// record layout and a small helper that clamps the requested mine count.
package buscaminas_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CELLS = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PLACE = 3'd2,
    COUNT = 3'd3,
    PLAY  = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } bm_state_t;

  typedef struct packed {
    logic       flag;
    logic       revealed;
    logic       mine;
    logic [3:0] count;
  } cell_t;

  // A game needs at least one mine, otherwise it could never be lost.
  function automatic logic [5:0] clip_target(input logic [5:0] req);
    logic [5:0] res;
    if (req == 6'd0) begin
      res = 6'd1;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/buscaminas_control_if.sv
// Valid/ready channel carrying random mine positions into the sequencer.
//   rnd_valid : source has a position available
//   rnd_pos   : cell index {row[2:0], col[2:0]}
//   rnd_ready : sequencer is accepting positions
interface buscaminas_control_if;
  logic       rnd_valid;
  logic [5:0] rnd_pos;
  logic       rnd_ready;

  modport master (output rnd_valid, output rnd_pos, input rnd_ready);
  modport slave  (input rnd_valid, input rnd_pos, output rnd_ready);
endinterface

// File: rtl/buscaminas_control_contador_vecinos.sv
// Combinational neighbour counter.
//   minas  : one bit per cell, set where a mine sits
//   idx    : cell being evaluated {row[2:0], col[2:0]}
//   cuenta : number of mines among the up-to-8 neighbours (0..8)
// Neighbours outside the board are masked off rather than wrapped.
module contador_vecinos
  import buscaminas_pkg::*;
(
  input  logic [CELLS-1:0] minas,
  input  logic [5:0]       idx,
  output logic [3:0]       cuenta
);

  logic has_up_s;
  logic has_dn_s;
  logic has_lf_s;
  logic has_rt_s;
  logic [7:0] vec_s;

  assign has_up_s = (idx[5:3] != 3'd0);
  assign has_dn_s = (idx[5:3] != 3'd7);
  assign has_lf_s = (idx[2:0] != 3'd0);
  assign has_rt_s = (idx[2:0] != 3'd7);

  // Select each neighbour; the 6-bit index wraps but the edge masks hide that.
  always_comb begin
    vec_s[0] = has_up_s & has_lf_s & minas[idx - 6'd9];
    vec_s[1] = has_up_s            & minas[idx - 6'd8];
    vec_s[2] = has_up_s & has_rt_s & minas[idx - 6'd7];
    vec_s[3] = has_lf_s            & minas[idx - 6'd1];
    vec_s[4] = has_rt_s            & minas[idx + 6'd1];
    vec_s[5] = has_dn_s & has_lf_s & minas[idx + 6'd7];
    vec_s[6] = has_dn_s            & minas[idx + 6'd8];
    vec_s[7] = has_dn_s & has_rt_s & minas[idx + 6'd9];
  end

  // Population count of the selected neighbours.
  always_comb begin
    cuenta = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cuenta = cuenta + {3'd0, vec_s[k]};
    end
  end

endmodule

// File: rtl/buscaminas_control.sv
// Minesweeper game sequencer for an 8x8 board.
//   clk, reset          : clock and synchronous active-high reset
//   start               : begin a new game (wins over every other input)
//   entrada_bombas      : requested mine count, latched on start
//   rnd                 : valid/ready channel of random mine positions
//   btn_*               : debounced single-cycle play buttons
//   cell_rd_addr/_data  : combinational board read port for the display
//   cursor_row/_col     : cursor position
//   state               : sequencer state encoding
//   flags_placed        : number of flagged cells
//   game_over, win      : end-of-game indicators
module buscaminas_control
  import buscaminas_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           entrada_bombas,
  buscaminas_control_if.slave  rnd,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_reveal,
  input  logic                 btn_flag,
  input  logic [5:0]           cell_rd_addr,
  output logic [6:0]           cell_rd_data,
  output logic [2:0]           cursor_row,
  output logic [2:0]           cursor_col,
  output logic [2:0]           state,
  output logic [6:0]           flags_placed,
  output logic                 game_over,
  output logic                 win
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  bm_state_t  state_q, state_d;
  cell_t      board_q [CELLS];
  cell_t      board_d [CELLS];
  logic [5:0] idx_q, idx_d;
  logic [5:0] placed_q, placed_d;
  logic [5:0] target_q, target_d;
  logic [5:0] rev_cnt_q, rev_cnt_d;
  logic [6:0] flags_q, flags_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       rnd_ready_q, rnd_ready_d;
  logic       game_over_q, game_over_d;
  logic       win_q, win_d;

  logic [CELLS-1:0] minas_s;
  logic [3:0]       cuenta_s;
  logic [5:0]       cur_s;

  assign cur_s = {row_q, col_q};

  // Flatten the mine bits for the neighbour counter.
  always_comb begin
    for (int i = 0; i < CELLS; i++) begin
      minas_s[i] = board_q[i].mine;
    end
  end

  contador_vecinos u_contador (
    .minas  (minas_s),
    .idx    (idx_q),
    .cuenta (cuenta_s)
  );

  // Next-state logic for the sequencer, board and counters.
  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    idx_d     = idx_q;
    placed_d  = placed_q;
    target_d  = target_q;
    rev_cnt_d = rev_cnt_q;
    flags_d   = flags_q;
    row_d     = row_q;
    col_d     = col_q;
    if (start) begin
      target_d  = clip_target(entrada_bombas);
      flags_d   = 7'd0;
      rev_cnt_d = 6'd0;
      placed_d  = 6'd0;
      idx_d     = 6'd0;
      state_d   = CLEAR;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CLEAR: begin
          board_d[idx_q] = '0;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d = PLACE;
          end else begin
            state_d = CLEAR;
          end
        end
        PLACE: begin
          // Duplicate positions are dropped without counting.
          if (rnd.rnd_valid && rnd_ready_q && !board_q[rnd.rnd_pos].mine) begin
            board_d[rnd.rnd_pos].mine = 1'b1;
            placed_d = placed_q + 6'd1;
          end else begin
            placed_d = placed_q;
          end
          if (placed_d == target_q) begin
            state_d = COUNT;
            idx_d   = 6'd0;
          end else begin
            state_d = PLACE;
          end
        end
        COUNT: begin
          board_d[idx_q].count = cuenta_s;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d = PLAY;
            row_d   = 3'd0;
            col_d   = 3'd0;
          end else begin
            state_d = COUNT;
          end
        end
        PLAY: begin
          if (btn_reveal) begin
            if (board_q[cur_s].flag || board_q[cur_s].revealed) begin
              state_d = PLAY;
            end else if (board_q[cur_s].mine) begin
              board_d[cur_s].revealed = 1'b1;
              state_d = LOSE;
            end else begin
              board_d[cur_s].revealed = 1'b1;
              rev_cnt_d = rev_cnt_q + 6'd1;
              // Won once every non-mine cell has been uncovered.
              if (({1'b0, rev_cnt_q} + 7'd1) == (7'd64 - {1'b0, target_q})) begin
                state_d = WIN;
              end else begin
                state_d = PLAY;
              end
            end
          end else if (btn_flag) begin
            if (board_q[cur_s].revealed) begin
              flags_d = flags_q;
            end else if (board_q[cur_s].flag) begin
              board_d[cur_s].flag = 1'b0;
              flags_d = flags_q - 7'd1;
            end else begin
              board_d[cur_s].flag = 1'b1;
              flags_d = flags_q + 7'd1;
            end
          end else if (btn_up) begin
            row_d = (row_q == 3'd0) ? row_q : row_q - 3'd1;
          end else if (btn_down) begin
            row_d = (row_q == LAST_ROW) ? row_q : row_q + 3'd1;
          end else if (btn_left) begin
            col_d = (col_q == 3'd0) ? col_q : col_q - 3'd1;
          end else if (btn_right) begin
            col_d = (col_q == LAST_COL) ? col_q : col_q + 3'd1;
          end else begin
            state_d = PLAY;
          end
        end
        WIN: begin
          state_d = WIN;
        end
        LOSE: begin
          state_d = LOSE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    // Status outputs follow the next state so they change on the same edge.
    rnd_ready_d = (state_d == PLACE);
    game_over_d = (state_d == WIN) || (state_d == LOSE);
    win_d       = (state_d == WIN);
  end

  // State and board registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < CELLS; i++) begin
        board_q[i] <= '0;
      end
      idx_q       <= 6'd0;
      placed_q    <= 6'd0;
      target_q    <= 6'd1;
      rev_cnt_q   <= 6'd0;
      flags_q     <= 7'd0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      rnd_ready_q <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      idx_q       <= idx_d;
      placed_q    <= placed_d;
      target_q    <= target_d;
      rev_cnt_q   <= rev_cnt_d;
      flags_q     <= flags_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rnd_ready_q <= rnd_ready_d;
      game_over_q <= game_over_d;
      win_q       <= win_d;
    end
  end

  assign rnd.rnd_ready = rnd_ready_q;
  assign cell_rd_data  = board_q[cell_rd_addr];
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign state         = state_q;
  assign flags_placed  = flags_q;
  assign game_over     = game_over_q;
  assign win           = win_q;

endmodule

// File: tb/tb_buscaminas_control.sv
// Self-checking bench for buscaminas_control. Expected values are pushed
// into a scoreboard queue as stimulus is applied and compared after the
// clock edge that should produce them.
module tb_buscaminas_control;
  import buscaminas_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] entrada_bombas;
  logic       btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;
  logic [5:0] cell_rd_addr;
  logic [6:0] cell_rd_data;
  logic [2:0] cursor_row, cursor_col, state;
  logic [6:0] flags_placed;
  logic       game_over, win;

  buscaminas_control_if rnd_if ();

  buscaminas_control dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .entrada_bombas (entrada_bombas),
    .rnd            (rnd_if),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_reveal     (btn_reveal),
    .btn_flag       (btn_flag),
    .cell_rd_addr   (cell_rd_addr),
    .cell_rd_data   (cell_rd_data),
    .cursor_row     (cursor_row),
    .cursor_col     (cursor_col),
    .state          (state),
    .flags_placed   (flags_placed),
    .game_over      (game_over),
    .win            (win)
  );

  // Free-running clock.
  always #100 clk = ~clk;

  localparam int SEL_STATE = 0, SEL_READY = 1, SEL_CELL = 2, SEL_ROW = 3;
  localparam int SEL_COL = 4, SEL_FLAGS = 5, SEL_OVER = 6, SEL_WIN = 7;
  // Button vector layout {reveal, flag, up, down, left, right}.
  localparam logic [5:0] B_REV = 6'b100000, B_FLAG = 6'b010000, B_UP = 6'b001000;
  localparam logic [5:0] B_DN = 6'b000100, B_LF = 6'b000010, B_RT = 6'b000001;

  typedef struct {
    string tag;
    int    sel;
    int    addr;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mines [64];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      SEL_STATE: return {29'd0, state};
      SEL_READY: return {31'd0, rnd_if.rnd_ready};
      SEL_CELL:  return {25'd0, cell_rd_data};
      SEL_ROW:   return {29'd0, cursor_row};
      SEL_COL:   return {29'd0, cursor_col};
      SEL_FLAGS: return {25'd0, flags_placed};
      SEL_OVER:  return {31'd0, game_over};
      SEL_WIN:   return {31'd0, win};
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int addr, input int exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = addr; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == SEL_CELL) begin
        cell_rd_addr = 6'(e.addr);
        #1;
      end
      check_val(e.tag, obs(e.sel), 32'(e.exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int nb_count(input int i);
    int r, c, n;
    r = i / 8; c = i % 8; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
          if (mines[(r + dr) * 8 + c + dc]) n++;
    return n;
  endfunction

  function automatic int cell_exp(input int i, input int rev, input int flg);
    return flg * 64 + rev * 32 + (mines[i] ? 16 : 0) + nb_count(i);
  endfunction

  task automatic press(input logic [5:0] b);
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
    step();
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 6'd0;
    drain();
  endtask

  task automatic do_start(input int n, input logic [5:0] b);
    entrada_bombas = 6'(n);
    start = 1'b1;
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = b;
    push("start_state", SEL_STATE, 0, 1);
    push("start_flags", SEL_FLAGS, 0, 0);
    step();
    start = 1'b0;
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 6'd0;
    drain();
    for (int i = 0; i < 64; i++) mines[i] = 1'b0;
  endtask

  task automatic to_place();
    push("clear_len", SEL_STATE, 0, 1);
    step_n(63);
    drain();
    push("place_state", SEL_STATE, 0, 2);
    push("place_ready", SEL_READY, 0, 1);
    step();
    drain();
  endtask

  task automatic place(input int pos, input bit is_new, input int exp_state);
    rnd_if.rnd_valid = 1'b1;
    rnd_if.rnd_pos   = 6'(pos);
    if (is_new) mines[pos] = 1'b1;
    push("place_next", SEL_STATE, 0, exp_state);
    push("place_rdy", SEL_READY, 0, (exp_state == 2) ? 1 : 0);
    step();
    rnd_if.rnd_valid = 1'b0;
    drain();
  endtask

  task automatic run_count();
    push("count_len", SEL_STATE, 0, 3);
    step_n(63);
    drain();
    push("play_state", SEL_STATE, 0, 4);
    push("play_row", SEL_ROW, 0, 0);
    push("play_col", SEL_COL, 0, 0);
    step();
    drain();
  endtask

  task automatic check_board();
    for (int i = 0; i < 64; i++) push("board", SEL_CELL, i, cell_exp(i, 0, 0));
    drain();
  endtask

  // Safety net against a stuck simulation.
  initial begin
    #4000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int reveals;
    int col_now;
    reset = 1'b1; start = 1'b0; entrada_bombas = 6'd0;
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 6'd0;
    rnd_if.rnd_valid = 1'b0; rnd_if.rnd_pos = 6'd0; cell_rd_addr = 6'd0;
    for (int i = 0; i < 64; i++) mines[i] = 1'b0;
    step_n(2);
    push("rst_state", SEL_STATE, 0, 0);
    push("rst_ready", SEL_READY, 0, 0);
    push("rst_row", SEL_ROW, 0, 0);
    push("rst_col", SEL_COL, 0, 0);
    push("rst_flags", SEL_FLAGS, 0, 0);
    push("rst_over", SEL_OVER, 0, 0);
    push("rst_win", SEL_WIN, 0, 0);
    push("rst_cell", SEL_CELL, 0, 0);
    drain();
    reset = 1'b0;
    push("idle_hold", SEL_STATE, 0, 0);
    step();
    drain();

    // Reset in the middle of PLACE.
    do_start(10, 6'd0);
    to_place();
    place(3, 1'b1, 2); place(17, 1'b1, 2); place(40, 1'b1, 2); place(41, 1'b1, 2);
    reset = 1'b1;
    push("midrst_state", SEL_STATE, 0, 0);
    push("midrst_ready", SEL_READY, 0, 0);
    for (int i = 0; i < 64; i++) push("midrst_cell", SEL_CELL, i, 0);
    step();
    reset = 1'b0;
    drain();
    for (int i = 0; i < 64; i++) mines[i] = 1'b0;

    // Three mines with a duplicate position.
    do_start(3, 6'd0);
    to_place();
    place(5, 1'b1, 2); place(5, 1'b0, 2); place(9, 1'b1, 2); place(63, 1'b1, 3);
    run_count();
    check_board();

    // Cursor saturation and reveal priority.
    push("up_row", SEL_ROW, 0, 0);
    press(B_UP);
    push("left_col", SEL_COL, 0, 0);
    press(B_LF);
    push("revdn_cell", SEL_CELL, 0, cell_exp(0, 1, 0));
    push("revdn_row", SEL_ROW, 0, 0);
    press(B_REV | B_DN);
    for (int k = 1; k < 8; k++) begin
      push("down_row", SEL_ROW, 0, k);
      press(B_DN);
    end
    push("down_sat", SEL_ROW, 0, 7);
    press(B_DN);
    for (int k = 1; k < 8; k++) begin
      push("right_col", SEL_COL, 0, k);
      press(B_RT);
    end
    push("right_sat", SEL_COL, 0, 7);
    press(B_RT);

    // Start together with reveal on a mine: start wins.
    push("startrev_cell", SEL_CELL, 63, cell_exp(63, 0, 0));
    push("startrev_over", SEL_OVER, 0, 0);
    do_start(2, B_REV);
    to_place();
    place(20, 1'b1, 2); place(30, 1'b1, 3);

    // Zero requested mines becomes one; reveal every safe cell.
    do_start(0, 6'd0);
    to_place();
    place(0, 1'b1, 3);
    run_count();
    push("flag_cnt", SEL_FLAGS, 0, 1);
    push("flag_cell", SEL_CELL, 0, cell_exp(0, 0, 1));
    press(B_FLAG);
    push("revflag_state", SEL_STATE, 0, 4);
    push("revflag_cell", SEL_CELL, 0, cell_exp(0, 0, 1));
    press(B_REV);
    push("unflag_cnt", SEL_FLAGS, 0, 0);
    push("unflag_cell", SEL_CELL, 0, cell_exp(0, 0, 0));
    press(B_FLAG);
    reveals = 0;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 8; j++) begin
        col_now = (r % 2 == 0) ? j : 7 - j;
        if (r * 8 + col_now != 0) begin
          reveals++;
          push("sweep_win", SEL_WIN, 0, (reveals == 63) ? 1 : 0);
          push("sweep_state", SEL_STATE, 0, (reveals == 63) ? 5 : 4);
          press(B_REV);
        end
        if (j < 7) begin
          push("sweep_col", SEL_COL, 0, (r % 2 == 0) ? col_now + 1 : col_now - 1);
          press((r % 2 == 0) ? B_RT : B_LF);
        end else if (r < 7) begin
          push("sweep_row", SEL_ROW, 0, r + 1);
          press(B_DN);
        end
      end
    end
    push("win_over", SEL_OVER, 0, 1);
    push("win_hold", SEL_STATE, 0, 5);
    press(B_REV);
    push("win_up", SEL_ROW, 0, 7);
    press(B_UP);
    push("win_right", SEL_COL, 0, 0);
    press(B_RT);

    // Losing game: mine at (0,0).
    do_start(0, 6'd0);
    to_place();
    place(0, 1'b1, 3);
    run_count();
    push("lflag_cnt", SEL_FLAGS, 0, 1);
    press(B_FLAG);
    push("lrevflag_state", SEL_STATE, 0, 4);
    push("lrevflag_cell", SEL_CELL, 0, cell_exp(0, 0, 1));
    press(B_REV);
    push("lunflag_cnt", SEL_FLAGS, 0, 0);
    press(B_FLAG);
    push("lose_state", SEL_STATE, 0, 6);
    push("lose_over", SEL_OVER, 0, 1);
    push("lose_win", SEL_WIN, 0, 0);
    push("lose_cell", SEL_CELL, 0, cell_exp(0, 1, 0));
    press(B_REV);
    push("lose_down", SEL_ROW, 0, 0);
    press(B_DN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
